// File: rtl/seq_checker_pkg.sv
// Shared types and constants for the incrementing-sequence checker.
package seq_checker_pkg;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_LOCKING = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  localparam int unsigned SMP_W = 32;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear that takes priority over increment.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         ref_clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge ref_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seq_checker.sv
// Locks onto a modulo-2^WIDTH incrementing stream, then flags and counts deviations.
module seq_checker
  import seq_checker_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned LOSS_CNT = 3,
  parameter int unsigned ERR_W    = 16
) (
  input  logic             ref_clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt,
  output logic [SMP_W-1:0] smp_cnt
);

  localparam logic [7:0] LOCK_RUN = 8'(LOCK_CNT);
  localparam logic [7:0] LOSS_RUN = 8'(LOSS_CNT);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [7:0]       run_q, run_d;
  logic [7:0]       run_inc;
  logic             match;
  logic             err_ev;
  logic             smp_ev;

  assign match   = (in_data == exp_q);
  assign run_inc = run_q + 8'd1;

  always_ff @(posedge ref_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_SEARCH;
      exp_q     <= '0;
      run_q     <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      state_q   <= state_d;
      exp_q     <= exp_d;
      run_q     <= run_d;
      locked    <= (state_d == ST_LOCKED);
      err_pulse <= err_ev;
    end
  end

  // exp re-seeds from every valid sample, matching or not.
  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    run_d   = run_q;
    if (in_valid) begin
      exp_d = in_data + WIDTH'(1);
      unique case (state_q)
        ST_SEARCH: begin
          state_d = ST_LOCKING;
          run_d   = '0;
        end
        ST_LOCKING: begin
          if (!match) begin
            run_d = '0;
          end else if (run_inc == LOCK_RUN) begin
            state_d = ST_LOCKED;
            run_d   = '0;
          end else begin
            run_d = run_inc;
          end
        end
        ST_LOCKED: begin
          if (match) begin
            run_d = '0;
          end else if (run_inc == LOSS_RUN) begin
            state_d = ST_SEARCH;
            run_d   = '0;
          end else begin
            run_d = run_inc;
          end
        end
        default: begin
          state_d = ST_SEARCH;
          run_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    smp_ev = in_valid && (state_q == ST_LOCKED);
    err_ev = smp_ev && !match;
  end

  sat_counter #(.W(ERR_W)) u_err_cnt (
    .ref_clk (ref_clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .inc     (err_ev),
    .cnt     (err_cnt)
  );

  sat_counter #(.W(SMP_W)) u_smp_cnt (
    .ref_clk (ref_clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .inc     (smp_ev),
    .cnt     (smp_cnt)
  );

endmodule
